// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-requester RAM port arbiter.
package ram_port_arbiter_pkg;

  // Requester IDs, also used as bit positions in the req/gnt vectors
  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  // Default geometry of the shared simple dual-port RAM
  localparam int D_WIDTH_DEF = 16;
  localparam int A_WIDTH_DEF = 5;

  // Round-robin priority: the requester that was not granted last wins a tie
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr2.sv
// Two-way round-robin arbiter with a last-granted pointer.
// Grants are combinational; the pointer moves only when a grant is issued.
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 = requester 1 was granted last, so requester 0 wins the next tie
  logic last;

  // Grant selection, held off entirely while reset is asserted
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      gnt = rr_pick(req, last);
    end
  end

  // Pointer update on every grant; reset favours requester 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (gnt[REQ1]) begin
      last <= 1'b1;
    end else if (gnt[REQ0]) begin
      last <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a simple dual-port RAM between requesters r0 and r1.
// Independent round-robin arbitration on the write and read ports, read data
// returned one cycle after grant, same-address write/read forwarding.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  // requester 0
  input  logic               r0_wr_req,
  input  logic [A_WIDTH-1:0] r0_wr_addr,
  input  logic [D_WIDTH-1:0] r0_wr_data,
  output logic               r0_wr_gnt,
  input  logic               r0_rd_req,
  input  logic [A_WIDTH-1:0] r0_rd_addr,
  output logic               r0_rd_gnt,
  output logic               r0_rd_valid,
  output logic [D_WIDTH-1:0] r0_rd_data,
  // requester 1
  input  logic               r1_wr_req,
  input  logic [A_WIDTH-1:0] r1_wr_addr,
  input  logic [D_WIDTH-1:0] r1_wr_data,
  output logic               r1_wr_gnt,
  input  logic               r1_rd_req,
  input  logic [A_WIDTH-1:0] r1_rd_addr,
  output logic               r1_rd_gnt,
  output logic               r1_rd_valid,
  output logic [D_WIDTH-1:0] r1_rd_data,
  // RAM side
  output logic [A_WIDTH-1:0] address_write,
  output logic [D_WIDTH-1:0] data_write,
  output logic               write_enable,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read
);

  logic [1:0]         wr_req;
  logic [1:0]         wr_gnt;
  logic [1:0]         rd_req;
  logic [1:0]         rd_gnt;
  logic               rd_any;
  logic               collide;

  // Read-return tracking: a read is in flight, who owns it, and whether
  // the RAM output must be replaced by forwarded write data
  logic               rd_pending;
  logic               rd_owner;
  logic               byp;
  logic [D_WIDTH-1:0] byp_data;
  logic [D_WIDTH-1:0] rd_data_sel;

  assign wr_req = {r1_wr_req, r0_wr_req};
  assign rd_req = {r1_rd_req, r0_rd_req};

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .req   (wr_req),
    .gnt   (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .req   (rd_req),
    .gnt   (rd_gnt)
  );

  assign r0_wr_gnt = wr_gnt[REQ0];
  assign r1_wr_gnt = wr_gnt[REQ1];
  assign r0_rd_gnt = rd_gnt[REQ0];
  assign r1_rd_gnt = rd_gnt[REQ1];
  assign rd_any    = |rd_gnt;

  // Write port mux: winner's address/data, all zero when nobody is granted
  always_comb begin
    write_enable  = |wr_gnt;
    address_write = '0;
    data_write    = '0;
    if (wr_gnt[REQ0]) begin
      address_write = r0_wr_addr;
      data_write    = r0_wr_data;
    end else if (wr_gnt[REQ1]) begin
      address_write = r1_wr_addr;
      data_write    = r1_wr_data;
    end
  end

  // Read port mux: winner's address, zero when idle
  always_comb begin
    address_read = '0;
    if (rd_gnt[REQ0]) begin
      address_read = r0_rd_addr;
    end else if (rd_gnt[REQ1]) begin
      address_read = r1_rd_addr;
    end
  end

  // The RAM returns the old contents when the same word is written and read
  // on one edge, so that case is flagged and the new data captured here
  assign collide = write_enable & rd_any & (address_write == address_read);

  // Read-return and bypass registers; reset drops any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
      byp        <= 1'b0;
      byp_data   <= '0;
    end else begin
      rd_pending <= rd_any;
      if (rd_any) begin
        rd_owner <= rd_gnt[REQ1];
      end
      byp <= collide;
      if (collide) begin
        byp_data <= data_write;
      end
    end
  end

  assign rd_data_sel = byp ? byp_data : data_read;

  // Return path: only the owner sees valid, and data is zero otherwise
  assign r0_rd_valid = rd_pending & ~rd_owner;
  assign r1_rd_valid = rd_pending &  rd_owner;
  assign r0_rd_data  = r0_rd_valid ? rd_data_sel : '0;
  assign r1_rd_data  = r1_rd_valid ? rd_data_sel : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed test of ram_port_arbiter with a behavioural RAM and a read scoreboard.
module tb_ram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_wr_req, r1_wr_req, r0_rd_req, r1_rd_req;
  logic [AW-1:0] r0_wr_addr, r1_wr_addr, r0_rd_addr, r1_rd_addr;
  logic [DW-1:0] r0_wr_data, r1_wr_data;
  logic          r0_wr_gnt, r1_wr_gnt, r0_rd_gnt, r1_rd_gnt;
  logic          r0_rd_valid, r1_rd_valid;
  logic [DW-1:0] r0_rd_data, r1_rd_data;
  logic [AW-1:0] address_write, address_read;
  logic [DW-1:0] data_write, data_read;
  logic          write_enable;

  int n_checks = 0;
  int n_fail   = 0;

  // expected read data per requester, pushed at grant, popped at valid
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  // bench's view of RAM contents and arbitration pointers
  logic [DW-1:0] model_mem [2**AW];
  logic          wr_last_m, rd_last_m;

  always #5 clk = ~clk;

  ram_port_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .r0_wr_req(r0_wr_req), .r0_wr_addr(r0_wr_addr), .r0_wr_data(r0_wr_data), .r0_wr_gnt(r0_wr_gnt),
    .r0_rd_req(r0_rd_req), .r0_rd_addr(r0_rd_addr), .r0_rd_gnt(r0_rd_gnt),
    .r0_rd_valid(r0_rd_valid), .r0_rd_data(r0_rd_data),
    .r1_wr_req(r1_wr_req), .r1_wr_addr(r1_wr_addr), .r1_wr_data(r1_wr_data), .r1_wr_gnt(r1_wr_gnt),
    .r1_rd_req(r1_rd_req), .r1_rd_addr(r1_rd_addr), .r1_rd_gnt(r1_rd_gnt),
    .r1_rd_valid(r1_rd_valid), .r1_rd_data(r1_rd_data),
    .address_write(address_write), .data_write(data_write), .write_enable(write_enable),
    .address_read(address_read), .data_read(data_read)
  );

  // behavioural simple dual-port RAM, read-first, registered read
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (write_enable) ram[address_write] <= data_write;
    data_read <= ram[address_read];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  // read-return monitor: valid must match the scoreboard, data zero when idle
  always @(negedge clk) begin
    logic [DW-1:0] e;
    check("r0_rd_valid", 32'(r0_rd_valid), 32'(q0.size() != 0));
    if (q0.size() != 0) begin
      e = q0.pop_front();
      check("r0_rd_data", 32'(r0_rd_data), 32'(e));
    end else begin
      check("r0_rd_data_idle", 32'(r0_rd_data), 32'd0);
    end
    check("r1_rd_valid", 32'(r1_rd_valid), 32'(q1.size() != 0));
    if (q1.size() != 0) begin
      e = q1.pop_front();
      check("r1_rd_data", 32'(r1_rd_data), 32'(e));
    end else begin
      check("r1_rd_data_idle", 32'(r1_rd_data), 32'd0);
    end
  end

  // one arbitration cycle: inputs already driven after a falling edge
  task automatic tick();
    logic [1:0]    wg, rg;
    logic [AW-1:0] ewa, era;
    logic [DW-1:0] ewd, erd;
    #1;
    wg  = pick({r1_wr_req, r0_wr_req}, wr_last_m);
    rg  = pick({r1_rd_req, r0_rd_req}, rd_last_m);
    ewa = wg[0] ? r0_wr_addr : (wg[1] ? r1_wr_addr : '0);
    ewd = wg[0] ? r0_wr_data : (wg[1] ? r1_wr_data : '0);
    era = rg[0] ? r0_rd_addr : (rg[1] ? r1_rd_addr : '0);
    check("r0_wr_gnt", 32'(r0_wr_gnt), 32'(wg[0]));
    check("r1_wr_gnt", 32'(r1_wr_gnt), 32'(wg[1]));
    check("r0_rd_gnt", 32'(r0_rd_gnt), 32'(rg[0]));
    check("r1_rd_gnt", 32'(r1_rd_gnt), 32'(rg[1]));
    check("write_enable", 32'(write_enable), 32'(wg != 2'b00));
    check("address_write", 32'(address_write), 32'(ewa));
    check("data_write", 32'(data_write), 32'(ewd));
    check("address_read", 32'(address_read), 32'(era));
    $display("cycle t=%0t wg=%b rg=%b wa=%0d wd=%h ra=%0d", $time, wg, rg, ewa, ewd, era);
    if (rg != 2'b00) begin
      erd = (wg != 2'b00 && ewa == era) ? ewd : model_mem[era];
      if (rg[0]) q0.push_back(erd);
      else       q1.push_back(erd);
      rd_last_m = rg[1];
    end
    if (wg != 2'b00) begin
      model_mem[ewa] = ewd;
      wr_last_m = wg[1];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    r0_wr_req = 0; r1_wr_req = 0; r0_rd_req = 0; r1_rd_req = 0;
  endtask

  task automatic wr(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin r0_wr_req = 1; r0_wr_addr = a; r0_wr_data = d; end
    else        begin r1_wr_req = 1; r1_wr_addr = a; r1_wr_data = d; end
  endtask

  task automatic rd(input int n, input logic [AW-1:0] a);
    if (n == 0) begin r0_rd_req = 1; r0_rd_addr = a; end
    else        begin r1_rd_req = 1; r1_rd_addr = a; end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_r0_wr_gnt"}, 32'(r0_wr_gnt), 32'd0);
    check({tag, "_r1_wr_gnt"}, 32'(r1_wr_gnt), 32'd0);
    check({tag, "_r0_rd_gnt"}, 32'(r0_rd_gnt), 32'd0);
    check({tag, "_r1_rd_gnt"}, 32'(r1_rd_gnt), 32'd0);
    check({tag, "_write_enable"}, 32'(write_enable), 32'd0);
    check({tag, "_address_write"}, 32'(address_write), 32'd0);
    check({tag, "_data_write"}, 32'(data_write), 32'd0);
    check({tag, "_address_read"}, 32'(address_read), 32'd0);
    check({tag, "_r0_rd_valid"}, 32'(r0_rd_valid), 32'd0);
    check({tag, "_r1_rd_valid"}, 32'(r1_rd_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    idle();
    r0_wr_addr = 0; r1_wr_addr = 0; r0_rd_addr = 0; r1_rd_addr = 0;
    r0_wr_data = 0; r1_wr_data = 0;
    wr_last_m = 1; rd_last_m = 1;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    // grants forced low while reset is high, even with requests
    wr(0, 5'd1, 16'h1); rd(1, 5'd1);
    #1;
    check_quiet("reset_req");
    idle();
    @(negedge clk);
    reset = 0;

    // single write then read by the other requester
    wr(0, 5'd3, 16'hA5A5); tick(); idle();
    rd(1, 5'd3); tick(); idle();

    // preload by r1 so r0 has priority at the first write contention
    wr(1, 5'd7, 16'h0001); tick(); idle();
    wr(1, 5'd9, 16'h1234); tick(); idle();

    // write contention, 4 cycles: r0, r1, r0, r1
    for (int i = 0; i < 4; i++) begin
      wr(0, 5'd1, 16'h1000 + 16'(i));
      wr(1, 5'd2, 16'h2000 + 16'(i));
      #1;
      check("wr_rr_seq", 32'(r0_wr_gnt), 32'(i % 2 == 0));
      tick();
    end
    idle();

    // read contention, back-to-back, no bubbles
    for (int i = 0; i < 6; i++) begin
      rd(0, 5'd1); rd(1, 5'd2);
      tick();
    end
    idle();

    // back-to-back single-requester reads: valid stays high
    for (int i = 1; i <= 3; i++) begin
      rd(0, 5'(i)); tick();
    end
    idle();

    // collision, different requesters: reader sees new data
    wr(0, 5'd7, 16'hBEEF); rd(1, 5'd7); tick(); idle();
    // collision, same requester writes and reads
    wr(0, 5'd7, 16'hCAFE); rd(0, 5'd7); tick(); idle();
    rd(1, 5'd7); tick(); idle();

    // concurrent ports on different addresses
    wr(0, 5'd4, 16'h4444); rd(1, 5'd9); tick(); idle();
    rd(1, 5'd4); tick(); idle();

    // reset in the middle of an r0 read (r0 was also last writer)
    rd(0, 5'd9);
    #1;
    check("mid_r0_rd_gnt", 32'(r0_rd_gnt), 32'd1);
    @(posedge clk);
    #2;
    reset = 1;
    wr(0, 5'd5, 16'h5555); wr(1, 5'd6, 16'h6666); rd(1, 5'd9);
    #1;
    check_quiet("mid_reset");
    @(negedge clk);
    @(negedge clk);
    #1;
    check_quiet("mid_reset_hold");
    idle();
    @(negedge clk);
    reset = 0;
    wr_last_m = 1; rd_last_m = 1;
    q0.delete(); q1.delete();

    // first contention after reset goes to r0 on both ports
    wr(0, 5'd5, 16'h5555); wr(1, 5'd6, 16'h6666); rd(0, 5'd9); rd(1, 5'd3);
    #1;
    check("post_reset_wr_r0", 32'(r0_wr_gnt), 32'd1);
    check("post_reset_rd_r0", 32'(r0_rd_gnt), 32'd1);
    tick();
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
